// File: rtl/pdn_rail_sequencer.sv
// pdn_rail_sequencer
//
// Power-rail sequencer for the power distribution network. It enables NUM_RAILS supply rails
// strictly in index order. Each rail gets a programmable ramp delay, then a power-good
// handshake must complete before the next rail is enabled. Rails are disabled in reverse
// order on power-down. The first power-good fault is latched and every rail is dropped
// at once.
//
// Optional feature macro: PDN_SEQ_PG_SYNC_EN
//   defined   - rail_pg passes through a 2-flop synchronizer per bit, so every pg-related
//               latency (handshake, fault detection) is 2 cycles longer.
//   undefined - rail_pg is used directly and must be synchronous to clk.
//
// Ports:
//   clk        in   single clock
//   rst_n      in   asynchronous active-low reset
//   pwr_req    in   level request: 1 = power up, 0 = power down / clear fault
//   rail_dly   in   ramp delay of rail i in bits [i*CNT_W +: CNT_W], in cycles
//   rail_pg    in   power-good per rail
//   rail_en    out  registered rail enables
//   all_good   out  all rails up and good
//   busy       out  sequencing up or down
//   fault      out  latched fault
//   fault_rail out  index of the faulting rail
module pdn_rail_sequencer #(
  parameter int unsigned NUM_RAILS  = 6,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PG_TIMEOUT = 200,
  parameter int unsigned DOWN_GAP   = 4,
  localparam int unsigned IdxW      = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pwr_req,
  input  logic [NUM_RAILS*CNT_W-1:0] rail_dly,
  input  logic [NUM_RAILS-1:0]       rail_pg,
  output logic [NUM_RAILS-1:0]       rail_en,
  output logic                       all_good,
  output logic                       busy,
  output logic                       fault,
  output logic [IdxW-1:0]            fault_rail
);

  localparam int unsigned GapW = (DOWN_GAP > 1) ? $clog2(DOWN_GAP) : 1;

  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(NUM_RAILS - 1);
  localparam logic [CNT_W-1:0] PgTimeout = CNT_W'(PG_TIMEOUT);
  localparam logic [GapW-1:0]  GapReload = GapW'(DOWN_GAP - 1);

  typedef enum logic [2:0] {StIdle, StRamp, StWaitPg, StOn, StDown, StFault} state_e;

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [GapW-1:0]  gap_q;
  logic             req_q;

  logic [NUM_RAILS-1:0] pg;

`ifdef PDN_SEQ_PG_SYNC_EN
  logic [NUM_RAILS-1:0] pg_meta_q, pg_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_meta_q <= '0;
      pg_sync_q <= '0;
    end else begin
      pg_meta_q <= rail_pg;
      pg_sync_q <= pg_meta_q;
    end
  end

  assign pg = pg_sync_q;
`else
  assign pg = rail_pg;
`endif

  // Lowest rail with pg low: over all rails (ON) and over confirmed rails only (bring-up).
  logic            any_low, conf_low;
  logic [IdxW-1:0] low_idx, conf_idx;

  always_comb begin
    any_low  = 1'b0;
    low_idx  = '0;
    conf_low = 1'b0;
    conf_idx = '0;
    // Walk downwards so the last hit is the lowest index.
    for (int i = int'(NUM_RAILS) - 1; i >= 0; i--) begin
      if (!pg[i]) begin
        any_low = 1'b1;
        low_idx = IdxW'(i);
        if (IdxW'(i) < idx_q) begin
          conf_low = 1'b1;
          conf_idx = IdxW'(i);
        end
      end
    end
  end

  // Enable vector with its highest set bit removed.
  logic [NUM_RAILS-1:0] en_drop;

  always_comb begin
    en_drop = rail_en;
    for (int i = 0; i < int'(NUM_RAILS); i++) begin
      if (rail_en[i]) en_drop = rail_en & ~(NUM_RAILS'(1) << i);
    end
  end

  logic [IdxW-1:0]  idx_nxt;
  logic [CNT_W-1:0] dly_nxt;

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    dly_nxt = '0;
    for (int i = 0; i < int'(NUM_RAILS); i++) begin
      if (IdxW'(i) == idx_nxt) dly_nxt = rail_dly[i*CNT_W +: CNT_W];
    end
  end

  logic timeout;
  assign timeout = (state_q == StWaitPg) && !pg[idx_q] && (cnt_q == '0);

  // pwr_req is registered once; every request reaction is therefore one cycle after the
  // sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      req_q      <= 1'b0;
      rail_en    <= '0;
      all_good   <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= '0;
    end else begin
      req_q <= pwr_req;
      unique case (state_q)
        StIdle: begin
          if (req_q) begin
            state_q <= StRamp;
            idx_q   <= '0;
            cnt_q   <= rail_dly[CNT_W-1:0];
            rail_en <= NUM_RAILS'(1);
            busy    <= 1'b1;
          end
        end
        StRamp, StWaitPg: begin
          // Priority: lost confirmed rail, then timeout, then request drop, then progress.
          if (conf_low || timeout) begin
            state_q    <= StFault;
            rail_en    <= '0;
            busy       <= 1'b0;
            fault      <= 1'b1;
            fault_rail <= conf_low ? conf_idx : idx_q;
          end else if (!req_q) begin
            state_q <= StDown;
            gap_q   <= '0;
          end else if (state_q == StRamp) begin
            if (cnt_q == '0) begin
              state_q <= StWaitPg;
              cnt_q   <= PgTimeout;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end else if (pg[idx_q]) begin
            if (idx_q == LastIdx) begin
              state_q  <= StOn;
              busy     <= 1'b0;
              all_good <= 1'b1;
            end else begin
              state_q          <= StRamp;
              idx_q            <= idx_nxt;
              cnt_q            <= dly_nxt;
              rail_en[idx_nxt] <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StOn: begin
          if (any_low) begin
            state_q    <= StFault;
            rail_en    <= '0;
            all_good   <= 1'b0;
            fault      <= 1'b1;
            fault_rail <= low_idx;
          end else if (!req_q) begin
            state_q  <= StDown;
            gap_q    <= '0;
            all_good <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StDown: begin
          // One step every DOWN_GAP cycles: drop the highest rail, or finish once none is left.
          if (gap_q == '0) begin
            if (rail_en == '0) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              rail_en <= en_drop;
              gap_q   <= GapReload;
            end
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        StFault: begin
          if (!req_q) begin
            state_q <= StIdle;
            fault   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// tb_pdn_rail_sequencer
//
// Bench for pdn_rail_sequencer with default parameters. Every expected rail_en change is
// pushed to a queue (cycle, value) when stimulus is driven; a negedge monitor pops and
// compares each change the DUT makes. Status outputs are checked at computed cycles.
// Power-good is modelled as rail_en delayed by two clocks, with a per-rail kill mask.
module tb_pdn_rail_sequencer;

  localparam int NR  = 6;
  localparam int CW  = 8;
  localparam int GAP = 4;
`ifdef PDN_SEQ_PG_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           pwr_req;
  logic [NR*CW-1:0] rail_dly;
  logic [NR-1:0]  rail_pg;
  logic [NR-1:0]  rail_en;
  logic           all_good;
  logic           busy;
  logic           fault;
  logic [2:0]     fault_rail;

  logic [NR-1:0]  pg_d1, pg_d2, pg_kill;
  logic [NR-1:0]  prev_en = '0;
  int             cyc = 0;
  int             n_tests = 0;
  int             n_fail = 0;

  typedef struct {
    int            cyc;
    logic [NR-1:0] en;
  } ev_t;

  ev_t sb_q[$];

  pdn_rail_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwr_req    (pwr_req),
    .rail_dly   (rail_dly),
    .rail_pg    (rail_pg),
    .rail_en    (rail_en),
    .all_good   (all_good),
    .busy       (busy),
    .fault      (fault),
    .fault_rail (fault_rail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_d1 <= '0;
      pg_d2 <= '0;
    end else begin
      pg_d1 <= rail_en;
      pg_d2 <= pg_d1;
    end
  end

  assign rail_pg = pg_d2 & ~pg_kill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Scoreboard consumer: every rail_en change must match the next queued expectation.
  always @(negedge clk) begin
    if (rail_en !== prev_en) begin
      if (sb_q.size() == 0) begin
        check("en_unexpected", 32'(rail_en), 32'(prev_en));
      end else begin
        check("en_val", 32'(rail_en), 32'(sb_q[0].en));
        check("en_cyc", 32'(cyc), 32'(sb_q[0].cyc));
        sb_q.delete(0);
      end
      prev_en <= rail_en;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int step(input int d);
    return (d + 2 > 3 + SyncLat) ? d + 2 : 3 + SyncLat;
  endfunction

  function automatic int dly_of(input int i);
    return int'(rail_dly[i*CW +: CW]);
  endfunction

  task automatic set_dly(input int d, input int d3);
    for (int i = 0; i < NR; i++) rail_dly[i*CW +: CW] = CW'((i == 3) ? d3 : d);
  endtask

  task automatic push_ev(input int t, input logic [NR-1:0] en);
    ev_t ev;
    ev.cyc = t;
    ev.en  = en;
    sb_q.push_back(ev);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && sb_q.size() != 0; k++) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Raise pwr_req and queue the first n_up enables. Rail i+1 follows rail i by
  // rail_dly[i]+1+k, where pg (seen by the FSM) arrives 3+SyncLat cycles after an enable.
  task automatic start_up(input int n_up, output int t_last);
    int            e;
    logic [NR-1:0] en;
    pwr_req = 1'b1;
    e  = cyc + 2;
    en = '0;
    t_last = e;
    for (int i = 0; i < n_up; i++) begin
      en[i] = 1'b1;
      push_ev(e, en);
      t_last = e;
      e = e + step(dly_of(i));
    end
  endtask

  task automatic expect_down(input int t0, input logic [NR-1:0] en0, output int t_idle);
    logic [NR-1:0] en;
    int            t;
    en = en0;
    t  = t0;
    while (en != '0) begin
      for (int j = NR - 1; j >= 0; j--) begin
        if (en[j]) begin
          en[j] = 1'b0;
          break;
        end
      end
      push_ev(t, en);
      t = t + GAP;
    end
    t_idle = t;
  endtask

  task automatic drop_req(input logic [NR-1:0] en0, output int t_idle);
    int c;
    c = cyc;
    pwr_req = 1'b0;
    expect_down(c + 3, en0, t_idle);
    wait_cyc(c + 2);
    check("down_all_good", 32'(all_good), 32'd0);
    check("down_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    int t0, t_last, t_on, t_idle, t_f, c;

    rst_n   = 1'b0;
    pwr_req = 1'b0;
    pg_kill = '0;
    set_dly(3, 3);
    repeat (3) @(negedge clk);
    check("rst_en", 32'(rail_en), 32'd0);
    check("rst_all_good", 32'(all_good), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_rail", 32'(fault_rail), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal bring-up
    t0 = cyc;
    start_up(NR, t_last);
    t_on = t_last + step(dly_of(NR - 1));
    wait_cyc(t0 + 2);
    check("up_busy", 32'(busy), 32'd1);
    wait_cyc(t_on - 1);
    check("pre_on_all_good", 32'(all_good), 32'd0);
    check("pre_on_busy", 32'(busy), 32'd1);
    wait_cyc(t_on);
    check("on_all_good", 32'(all_good), 32'd1);
    check("on_busy", 32'(busy), 32'd0);
    check("on_fault", 32'(fault), 32'd0);
    wait_drain();
    repeat (3) @(negedge clk);

    // Power-down from ON
    drop_req('1, t_idle);
    wait_cyc(t_idle - 1);
    check("down_busy_end", 32'(busy), 32'd1);
    wait_cyc(t_idle);
    check("idle_busy", 32'(busy), 32'd0);
    wait_drain();
    repeat (6) @(negedge clk);

    // Timeout fault on rail 2
    pg_kill = 6'b000100;
    start_up(3, t_last);
    t_f = t_last + dly_of(2) + 202;
    push_ev(t_f, '0);
    wait_cyc(t_f - 1);
    check("to_pre_fault", 32'(fault), 32'd0);
    check("to_pre_busy", 32'(busy), 32'd1);
    wait_cyc(t_f);
    check("to_fault", 32'(fault), 32'd1);
    check("to_fault_rail", 32'(fault_rail), 32'd2);
    check("to_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("to_hold_fault", 32'(fault), 32'd1);
    check("to_hold_rail", 32'(fault_rail), 32'd2);
    c = cyc;
    pwr_req = 1'b0;
    wait_cyc(c + 1);
    check("to_clr_pre", 32'(fault), 32'd1);
    wait_cyc(c + 2);
    check("to_clr", 32'(fault), 32'd0);
    pg_kill = '0;
    wait_drain();
    repeat (6) @(negedge clk);

    // Fault in ON: rails 4 and 1 lost together
    start_up(NR, t_last);
    t_on = t_last + step(dly_of(NR - 1));
    wait_cyc(t_on);
    check("on2_all_good", 32'(all_good), 32'd1);
    repeat (3) @(negedge clk);
    c = cyc;
    pg_kill = 6'b010010;
    push_ev(c + 1 + SyncLat, '0);
    wait_cyc(c + SyncLat);
    check("onf_pre_fault", 32'(fault), 32'd0);
    wait_cyc(c + 1 + SyncLat);
    check("onf_fault", 32'(fault), 32'd1);
    check("onf_fault_rail", 32'(fault_rail), 32'd1);
    check("onf_all_good", 32'(all_good), 32'd0);
    pwr_req = 1'b0;
    pg_kill = '0;
    repeat (3) @(negedge clk);
    check("onf_clr", 32'(fault), 32'd0);
    check("onf_rail_held", 32'(fault_rail), 32'd1);
    wait_drain();
    repeat (6) @(negedge clk);

    // Abort while rail 3 is ramping
    set_dly(3, 40);
    start_up(4, t_last);
    wait_cyc(t_last + 5);
    check("ab_busy", 32'(busy), 32'd1);
    drop_req(6'b001111, t_idle);
    wait_cyc(t_idle - 1);
    check("ab_busy_end", 32'(busy), 32'd1);
    wait_cyc(t_idle);
    check("ab_idle", 32'(busy), 32'd0);
    check("ab_fault", 32'(fault), 32'd0);
    wait_drain();
    repeat (6) @(negedge clk);

    // Zero ramp delay
    set_dly(0, 0);
    start_up(NR, t_last);
    t_on = t_last + step(0);
    wait_cyc(t_on - 1);
    check("z_pre_all_good", 32'(all_good), 32'd0);
    wait_cyc(t_on);
    check("z_all_good", 32'(all_good), 32'd1);
    repeat (2) @(negedge clk);
    drop_req('1, t_idle);
    wait_cyc(t_idle);
    check("z_idle", 32'(busy), 32'd0);
    wait_drain();
    repeat (6) @(negedge clk);

    // Asynchronous reset in the middle of WAIT_PG
    set_dly(3, 3);
    pg_kill = 6'b000100;
    start_up(3, t_last);
    wait_cyc(t_last + dly_of(2) + 1 + 10);
    check("rs_busy", 32'(busy), 32'd1);
    check("rs_en", 32'(rail_en), 32'h07);
    push_ev(cyc + 1, '0);
    #2;
    rst_n   = 1'b0;
    pwr_req = 1'b0;
    #1;
    check("rs_en_async", 32'(rail_en), 32'd0);
    check("rs_busy_async", 32'(busy), 32'd0);
    check("rs_fault_async", 32'(fault), 32'd0);
    check("rs_all_good_async", 32'(all_good), 32'd0);
    check("rs_fault_rail_async", 32'(fault_rail), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    pg_kill = '0;
    wait_drain();
    repeat (4) @(negedge clk);
    check("rs_idle_en", 32'(rail_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
